pipe_stage_hs: RTL and testbench
================================

# pipe_stage_hs

Parametrised elastic pipeline register for the RISC-V pipeline datapath. It is the handshaked successor to the plain clear/enable stage flop and replaces ad-hoc stall/flush wiring between stages with a valid/ready interface. A two-entry skid buffer keeps `in_ready` registered and sustains one transfer per cycle. A synchronous flush clears in-flight contents, for example on branch mispredict or trap.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `CNT_WIDTH`, default 16: width of the stall counter (see Configuration).
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of all stage contents; highest priority after reset.
- `in_valid` input 1: upstream payload valid.
- `in_ready` output 1: stage can accept; registered.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: downstream payload valid; registered.
- `out_ready` input 1: downstream accepts.
- `out_data` output WIDTH: downstream payload; registered.
- `stall_cnt` output CNT_WIDTH: saturating count of output-stall cycles.

## Operation
- Transfer rules:
  - An upstream transfer occurs when `in_valid && in_ready`.
  - A downstream transfer occurs when `out_valid && out_ready`.
- Storage:
  - Main register (`out_data`/`out_valid`) feeds the output.
  - Skid register (`skid_data`/`skid_valid`) captures one beat while downstream is stalled.
  - `in_ready = !skid_valid`.
- States are derived from the valid bits:
  - EMPTY: `out_valid=0`, `skid_valid=0`.
  - FULL: `out_valid=1`, `skid_valid=0`.
  - SKID: `out_valid=1`, `skid_valid=1`.
- Transitions, evaluated when `flush=0`:
  - EMPTY with `in_valid`: main <= `in_data`; go to FULL. Without `in_valid`: stay in EMPTY.
  - FULL with in-transfer and out-transfer: main <= `in_data`; stay in FULL.
  - FULL with in-transfer and no out-transfer: skid <= `in_data`; go to SKID.
  - FULL with out-transfer and no in-transfer: go to EMPTY.
  - FULL with neither: hold.
  - SKID with `out_ready`: main <= skid; go to FULL. `in_ready` is 0 here, so no input is accepted.
  - SKID without `out_ready`: hold.
- Flush:
  - When `flush=1`, the next edge clears both valids and both data registers to 0. The stage goes to EMPTY.
  - Any coincident upstream or downstream handshake that cycle is discarded. Upstream must treat its beat as dropped.
- Ordering is strictly FIFO. No beat is duplicated or lost except on flush.
- Data registers load only on the transitions above and otherwise hold their value.

## Timing
- Reset (`reset=0`, asynchronous):
  - `out_valid=0`, `out_data=0`, skid cleared.
  - `in_ready=1` immediately.
  - `stall_cnt=0`.
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- `in_ready` falls one cycle after the first stalled accept while FULL. It rises the cycle after the SKID drain.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`. The stage itself holds `out_data` stable while `out_valid && !out_ready`.
- Reset deassertion is synchronised externally. The first accept can occur on the first edge after release.

## Configuration
- `PIPE_STAGE_HS_STALL_CNT_EN`
  - Defined: `stall_cnt` increments on each edge where `out_valid && !out_ready`, and saturates at all-ones.
    - It is cleared only by reset; flush does not clear it.
    - In a flush cycle the increment still applies if the stall condition held.
  - Undefined: `stall_cnt` is tied to 0 and no counter logic is instantiated. The port remains, so the interface is unchanged.

## Test plan
- Streaming: `out_ready=1`; drive beats 0x1..0x8 back-to-back. Expect `out_data` 0x1..0x8 on consecutive cycles, one cycle after input, with `in_ready` constantly 1.
- Skid fill/drain:
  - Stall: accept 0xA, drop `out_ready`, offer 0xB. Expect 0xB captured, `in_ready=0` the next cycle, and `out_data` held at 0xA.
  - Drain: raise `out_ready`. Expect 0xA then 0xB, and `in_ready` back to 1.
- Flush in SKID state: with 0xA and 0xB held, assert `flush` for one cycle alongside `in_valid` carrying 0xC. Expect `out_valid=0`, `out_data=0`, `in_ready=1` next cycle, and 0xC never emitted.
- Async reset mid-transfer: pull `reset` low between edges while in FULL. Expect `out_valid=0` and `in_ready=1` immediately, without waiting for a clock edge.
- Stall counter (macro defined, `CNT_WIDTH=4`): hold `out_valid=1`, `out_ready=0` for 20 cycles. Expect `stall_cnt` counting to 15 and saturating. With the macro undefined, expect `stall_cnt` to stay 0.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_HS_STALL_CNT_EN to build the saturating output-stall counter; otherwise stall_cnt is 0.
module pipe_stage_hs #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Encoding chosen so bit 0 is the main valid and bit 1 is the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] out_data_next;
  logic [WIDTH-1:0] skid_data_next;
  logic             skid_valid;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid  = state[0];
  assign skid_valid = state[1];
  assign in_ready   = !skid_valid;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      out_data  <= out_data_next;
      skid_data <= skid_data_next;
    end
  end

  always_comb begin
    state_next     = state;
    out_data_next  = out_data;
    skid_data_next = skid_data;
    if (flush) begin
      state_next     = EMPTY;
      out_data_next  = '0;
      skid_data_next = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data_next = in_data;
            state_next    = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            out_data_next = in_data;
          end else if (in_xfer) begin
            skid_data_next = in_data;
            state_next     = SKID;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain can happen.
          if (out_ready) begin
            out_data_next = skid_data;
            state_next    = FULL;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_HS_STALL_CNT_EN
  // Counts regardless of flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard testbench for pipe_stage_hs: directed stimulus pushes expected beats, a negedge monitor pops and compares.
// Stall counter expectations follow PIPE_STAGE_HS_STALL_CNT_EN.
module tb_pipe_stage_hs;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 4;
`ifdef PIPE_STAGE_HS_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CNT_WIDTH-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_stage_hs #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return just after it.
  task automatic apply_stimulus(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen mid-cycle completes on the next edge unless flushed.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat actual=%0h expected=none", out_data);
      end else begin
        check_output("scoreboard_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check_output("reset_in_ready",  32'(in_ready),  32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_data",  out_data,       32'd0);
    check_output("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    #11 reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(32'(i));
      apply_stimulus(1'b1, 32'(i), 1'b1, 1'b0);
      check_output("stream_in_ready", 32'(in_ready), 32'd1);
      check_output("stream_out_data", out_data, 32'(i));
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("stream_empty", 32'(out_valid), 32'd0);

    // Skid fill and drain
    exp_q.push_back(32'hA);
    apply_stimulus(1'b1, 32'hA, 1'b1, 1'b0);
    exp_q.push_back(32'hB);
    apply_stimulus(1'b1, 32'hB, 1'b0, 1'b0);
    check_output("skid_in_ready", 32'(in_ready), 32'd0);
    check_output("skid_out_data", out_data, 32'hA);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("skid_hold_data", out_data, 32'hA);
    check_output("skid_hold_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("drain_in_ready", 32'(in_ready), 32'd1);
    check_output("drain_out_data", out_data, 32'hB);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("drain_empty", 32'(out_valid), 32'd0);

    // Flush while in SKID; nothing pushed since all beats are dropped
    apply_stimulus(1'b1, 32'hA, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hB, 1'b0, 1'b0);
    check_output("pre_flush_in_ready", 32'(in_ready), 32'd0);
    apply_stimulus(1'b1, 32'hC, 1'b1, 1'b1);
    check_output("flush_out_valid", 32'(out_valid), 32'd0);
    check_output("flush_out_data",  out_data,       32'd0);
    check_output("flush_in_ready",  32'(in_ready),  32'd1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("post_flush_valid", 32'(out_valid), 32'd0);

    // Flush in FULL with coincident accept and downstream handshake
    apply_stimulus(1'b1, 32'hD, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hE, 1'b1, 1'b1);
    check_output("flush_full_valid", 32'(out_valid), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    // Async reset between edges while FULL
    apply_stimulus(1'b1, 32'h55, 1'b0, 1'b0);
    check_output("pre_reset_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("async_out_valid", 32'(out_valid), 32'd0);
    check_output("async_in_ready",  32'(in_ready),  32'd1);
    check_output("async_out_data",  out_data,       32'd0);
    check_output("async_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Stall counter saturation
    exp_q.push_back(32'h77);
    apply_stimulus(1'b1, 32'h77, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      check_output("stall_cnt", 32'(stall_cnt), CNT_EN ? ((k > 15) ? 32'd15 : 32'(k)) : 32'd0);
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("stall_cnt_drain", 32'(stall_cnt), CNT_EN ? 32'd15 : 32'd0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("stall_cnt_flush", 32'(stall_cnt), CNT_EN ? 32'd15 : 32'd0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
